// File: rtl/fetch_pkg.sv
// Shared types and encodings for the fetch/commit sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] PCSRC_INC    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bundle between sequencer and memory.
interface fetch_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC select; wraps at ADDRESS_WIDTH and forces word alignment.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [1:0]               pc_src,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [DATA_WIDTH-1:0]    alu,
  output logic [ADDRESS_WIDTH-1:0] pc_next
);

  logic [ADDRESS_WIDTH-1:0] sum;
  logic                     unused_hi;

  // Only the low address bits of the wide operands matter for a byte PC.
  assign unused_hi = ^{imm[DATA_WIDTH-1:ADDRESS_WIDTH], alu[DATA_WIDTH-1:ADDRESS_WIDTH]};

  always_comb begin
    sum = pc + ADDRESS_WIDTH'(4);
    case (pc_src)
      PCSRC_BRANCH: sum = pc + imm[ADDRESS_WIDTH-1:0];
      PCSRC_JALR:   sum = alu[ADDRESS_WIDTH-1:0];
      default:      sum = pc + ADDRESS_WIDTH'(4);
    endcase
  end

  assign pc_next = sum & ~ADDRESS_WIDTH'(3);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/commit controller: owns the PC, fetches over req/ready, commits one word per EXEC.
//   state | meaning
//   IDLE  | one cycle after reset release
//   FETCH | request outstanding at PC, waiting for ready (timeout guarded)
//   EXEC  | commit cycle, instruction presented; stall holds here
//   HALT  | halt instruction or fetch timeout; frozen until reset
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              ADDRESS_WIDTH = 8,
  parameter int              DATA_WIDTH    = 32,
  parameter int              COUNT_WIDTH   = 16,
  parameter int              TIMEOUT       = 15,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0]    HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fetch_sequencer_if.master        imem,
  input  logic [1:0]               PCsrc_i,
  input  logic [DATA_WIDTH-1:0]    ImmOp_i,
  input  logic [DATA_WIDTH-1:0]    ALUresult_i,
  input  logic                     stall_i,
  output logic [ADDRESS_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic                     instr_valid_o,
  output logic [COUNT_WIDTH-1:0]   retired_o,
  output logic                     halt_o,
  output logic                     err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc, pc_next;
  logic [TW-1:0]            tmo_cnt;
  logic                     is_halt;

  next_pc_calc #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_next_pc (
    .pc      (pc),
    .pc_src  (PCsrc_i),
    .imm     (ImmOp_i),
    .alu     (ALUresult_i),
    .pc_next (pc_next)
  );

  assign is_halt = (instr_o == HALT_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH: begin
        if (imem.ready)               state_nxt = EXEC;
        else if (tmo_cnt == TMO_LAST) state_nxt = HALT;
      end
      EXEC: begin
        if (!stall_i) state_nxt = is_halt ? HALT : FETCH;
      end
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr_o   <= '0;
      retired_o <= '0;
      halt_o    <= 1'b0;
      err_o     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.ready) begin
            instr_o <= imem.rdata;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            err_o   <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        EXEC: begin
          if (!stall_i) begin
            if (retired_o != '1) retired_o <= retired_o + COUNT_WIDTH'(1);
            // A halting instruction retires but leaves the PC pointing at itself.
            if (is_halt) halt_o <= 1'b1;
            else         pc     <= pc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign PC_o          = pc;
  assign imem.addr     = pc;
  assign imem.req      = (state == FETCH);
  assign instr_valid_o = (state == EXEC);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, branch/jalr wrap, stall, halt, timeout.
module tb_fetch_sequencer;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] imm = '0;
  logic [31:0] alu = '0;
  logic        stall = 1'b0;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic        valid;
  logic [15:0] retired;
  logic        halt;
  logic        err;

  int errors = 0;
  int checks = 0;

  fetch_sequencer_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) ifc ();

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (ifc.master),
    .PCsrc_i       (pcsrc),
    .ImmOp_i       (imm),
    .ALUresult_i   (alu),
    .stall_i       (stall),
    .PC_o          (pc),
    .instr_o       (instr),
    .instr_valid_o (valid),
    .retired_o     (retired),
    .halt_o        (halt),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_core(input string tag, input logic [7:0] e_pc, input logic e_req,
                          input logic e_valid, input logic [15:0] e_ret);
    chk({tag, ".pc"},      {24'h0, pc},       {24'h0, e_pc});
    chk({tag, ".req"},     {31'h0, ifc.req},  {31'h0, e_req});
    chk({tag, ".valid"},   {31'h0, valid},    {31'h0, e_valid});
    chk({tag, ".retired"}, {16'h0, retired},  {16'h0, e_ret});
  endtask

  task automatic chk_reset(input string tag);
    chk_core(tag, 8'h00, 1'b0, 1'b0, 16'd0);
    chk({tag, ".instr"}, instr, 32'h0);
    chk({tag, ".halt"}, {31'h0, halt}, 32'h0);
    chk({tag, ".err"},  {31'h0, err},  32'h0);
  endtask

  initial begin
    ifc.ready = 1'b1;
    ifc.rdata = ADDI;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_core("idle", 8'h00, 1'b0, 1'b0, 16'd0);

    // Sequential fetch with ready tied high
    tick(); chk_core("seq_f0", 8'h00, 1'b1, 1'b0, 16'd0);
    tick(); chk_core("seq_e0", 8'h00, 1'b0, 1'b1, 16'd0);
    chk("seq_instr", instr, ADDI);
    tick(); chk_core("seq_f1", 8'h04, 1'b1, 1'b0, 16'd1);
    tick(); chk_core("seq_e1", 8'h04, 1'b0, 1'b1, 16'd1);
    tick(); chk_core("seq_f2", 8'h08, 1'b1, 1'b0, 16'd2);
    tick(); chk_core("seq_e2", 8'h08, 1'b0, 1'b1, 16'd2);
    tick(); chk_core("seq_f3", 8'h0C, 1'b1, 1'b0, 16'd3);
    tick(); tick(); chk_core("seq_f4", 8'h10, 1'b1, 1'b0, 16'd4);

    // Branch backwards, then branch across the wrap
    pcsrc = 2'b01; imm = 32'hFFFF_FFF8;
    tick(); chk_core("br_e", 8'h10, 1'b0, 1'b1, 16'd4);
    tick(); chk_core("br_back", 8'h08, 1'b1, 1'b0, 16'd5);
    pcsrc = 2'b10; alu = 32'h0000_00FC;
    tick(); tick(); chk_core("jalr_fc", 8'hFC, 1'b1, 1'b0, 16'd6);
    pcsrc = 2'b01; imm = 32'h0000_0008;
    tick(); tick(); chk_core("br_wrap", 8'h04, 1'b1, 1'b0, 16'd7);
    pcsrc = 2'b10; alu = 32'h0000_0133;
    tick(); tick(); chk_core("jalr_mask", 8'h30, 1'b1, 1'b0, 16'd8);

    // Stall in EXEC; memory activity during EXEC must be ignored
    pcsrc = 2'b00; stall = 1'b1;
    tick(); chk_core("stall_a", 8'h30, 1'b0, 1'b1, 16'd8);
    ifc.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_core("stall_hold", 8'h30, 1'b0, 1'b1, 16'd8);
      chk("stall_instr", instr, ADDI);
    end
    stall = 1'b0; ifc.rdata = ADDI;
    tick(); chk_core("stall_rel", 8'h34, 1'b1, 1'b0, 16'd9);

    // Halt instruction committed at 0x0C
    pcsrc = 2'b10; alu = 32'h0000_000C;
    tick(); tick(); chk_core("to_0c", 8'h0C, 1'b1, 1'b0, 16'd10);
    pcsrc = 2'b00; ifc.rdata = ECALL;
    tick(); chk_core("halt_e", 8'h0C, 1'b0, 1'b1, 16'd10);
    tick(); chk_core("halt", 8'h0C, 1'b0, 1'b0, 16'd11);
    chk("halt_flag", {31'h0, halt}, 32'h1);
    chk("halt_err", {31'h0, err}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_core("halt_frozen", 8'h0C, 1'b0, 1'b0, 16'd11);
    end

    // Asynchronous reset out of HALT
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_halt");

    // Fetch timeout
    @(negedge clk);
    ifc.ready = 1'b0; ifc.rdata = ADDI;
    rst_n = 1'b1;
    tick(); chk_core("tmo_f", 8'h00, 1'b1, 1'b0, 16'd0);
    repeat (14) tick();
    chk_core("tmo_14", 8'h00, 1'b1, 1'b0, 16'd0);
    chk("tmo_14_err", {31'h0, err}, 32'h0);
    tick(); chk_core("tmo_15", 8'h00, 1'b0, 1'b0, 16'd0);
    chk("tmo_15_err", {31'h0, err}, 32'h1);
    ifc.ready = 1'b1;
    tick(); tick(); chk_core("tmo_halt", 8'h00, 1'b0, 1'b0, 16'd0);
    chk("tmo_halt_err", {31'h0, err}, 32'h1);
    chk("tmo_halt_instr", instr, 32'h0);

    #2 rst_n = 1'b0;
    #1 chk_reset("rst_tmo");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
